beta_irq_ctrl: RTL
==================

# beta_irq_ctrl

Memory-mapped interrupt controller sitting directly upstream of the Beta core's `irq` input and on its data bus alongside data memory. It collects up to 8 external request lines, edge-detects and latches them as pending, masks them with a software enable register, and drives a single registered `irq` to the core. It arbitrates by fixed priority and holds the core's interrupt request through a handshake. Software reads the winning cause in the XADR handler and acknowledges it when done.

## Interface
- `N_SRC`, 8: number of request lines, 1..31.
- `BASE_ADDR`, 32'hFFFF_FF00: byte base of the 16-byte register window; bits [3:0] must be 0.

- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `src`  in  N_SRC  asynchronous request lines; a rising edge raises a request.
- `addr`  in  32  core DataAddress.
- `wdata`  in  32  core DataWrite.
- `we`  in  1  core WriteEnable.
- `re`  in  1  core ReadEnable.
- `sel`  out  1  combinational; 1 when addr[31:4] == BASE_ADDR[31:4]. Bus mux steers `rdata` to the core when set.
- `rdata`  out  32  combinational read data. Value is 0 when `sel` is 0 or the offset is unmapped.
- `irq`  out  1  registered interrupt request to the core.

## Operation
- Registers are decoded on addr[3:2]. Writes act only when `we & sel`. Reads act only when `re & sel`.
  - 0x0 PENDING: read returns pending bits. Write-1-to-clear.
  - 0x4 ENABLE: read/write, bits [N_SRC-1:0]. Upper bits read 0.
  - 0x8 CAUSE: read only. Value is {valid, 26'b0, index[4:0]}. Writes are ignored.
  - 0xC ACK: write any value to end service. Reads return 0.
- Edge detect: pending[i] is set when the synchronised src[i] is 1 and was 0 on the previous cycle. Levels do not re-trigger.
- If a set and a W1C hit the same bit in the same cycle, set wins.
- `active` = pending & enable. The winner is the lowest set index. `valid` = |active.
- The FSM has three states: IDLE, ASSERT, SERVICE.
  - IDLE -> ASSERT when valid. The `irq` register loads 1 on the same edge.
  - ASSERT -> SERVICE on a CAUSE read. On that edge the winner index is latched into `cause_q`, pending[cause_q] is cleared, and `irq` loads 0.
  - ASSERT -> IDLE if valid drops before the read (software masked or cleared it). `irq` loads 0.
  - SERVICE -> IDLE on an ACK write. New pending requests accumulate during SERVICE but `irq` stays 0.
  - ACK written in IDLE or ASSERT is ignored.
- CAUSE read data:
  - ASSERT: the current winner.
  - SERVICE: `cause_q` with valid=1.
  - IDLE: the current winner with valid=0 if none. Reading in IDLE has no side effect.
- Reset (including mid-service): state IDLE, pending 0, enable 0, `cause_q` 0, `irq` 0, synchroniser flops 0.

## Timing
- `rdata` and `sel` are purely combinational from addr/re/state/registers, with no wait states. This matches the core's single-cycle DataRead.
- All register updates and state changes occur on the rising `clk` edge.
- Let E0 be the edge on which src[i] is first sampled high, with the bit enabled and state IDLE:
  - with the macro: pending set at E2, `irq` = 1 after E3;
  - without the macro: pending set at E0, `irq` = 1 after E1.
- Enable-then-pending latency: an ENABLE write at edge Ek with the bit already pending gives `irq` = 1 after Ek+1.
- After the ACK edge, a remaining active request re-raises `irq` one edge later (IDLE -> ASSERT).
- The core registers `irq` internally, so `irq` must stay stable between edges. It is driven by a flop only.

## Configuration
- `BETA_IRQ_SYNC_EN` defined: each src bit passes through a 2-flop synchroniser before the edge-detect flop. This adds 2 cycles of latency.
- Not defined: src is used directly by the edge-detect flop. Only legal when the sources are already synchronous to `clk`.

## Structure
- Shared package `beta_irq_pkg` holds:
  - register offset constants `IRQ_OFF_PENDING/ENABLE/CAUSE/ACK`;
  - FSM state typedef `irq_state_t` (IDLE=0, ASSERT=1, SERVICE=2);
  - `IRQ_VALID_BIT` = 31.
- One sub-module, `irq_edge_sync`, parameterised by width. It contains the optional synchroniser plus the edge-detect flop and outputs a one-cycle rise pulse vector.
- The priority encoder is a package function, not a module.

## Test plan
- Reset, enable=0x01, src[0] rising -> `irq` 1 after 4 edges (macro on). CAUSE read returns 0x8000_0000 and `irq` 0 on the next edge. ACK -> IDLE.
- src[5] and src[2] rise together, enable=0xFF -> CAUSE=0x8000_0002. After ACK, `irq` re-asserts and CAUSE=0x8000_0005.
- src[3] held high for 20 cycles -> pending set exactly once. W1C 0x08 while src is still high -> pending stays 0.
- W1C on bit 1 in the same cycle a src[1] edge sets it -> PENDING reads 0x02.
- In SERVICE, src[4] rises -> `irq` stays 0 until ACK, then 1 one edge later.
- `rst` asserted in SERVICE with pending=0x30 -> next cycle `irq`=0, PENDING=0, ENABLE=0, CAUSE=0x0000_0000.

Source files
------------

// File: rtl/beta_irq_pkg.sv
// Shared definitions for the Beta interrupt controller: register offsets, FSM states
// and the fixed-priority encoder used to pick the winning request.
package beta_irq_pkg;

  localparam logic [3:0] IRQ_OFF_PENDING = 4'h0;
  localparam logic [3:0] IRQ_OFF_ENABLE  = 4'h4;
  localparam logic [3:0] IRQ_OFF_CAUSE   = 4'h8;
  localparam logic [3:0] IRQ_OFF_ACK     = 4'hC;

  localparam int IRQ_VALID_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [4:0] irq_prio_enc(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/beta_irq_ctrl_edge_sync.sv
// Request-line front end: optional 2-flop synchroniser (BETA_IRQ_SYNC_EN) followed by
// an edge-detect flop; rise_o pulses for one cycle per 0->1 transition.
module irq_edge_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] samp;
  logic [W-1:0] prev_q;

`ifdef BETA_IRQ_SYNC_EN
  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= src_i;
      s2_q <= s1_q;
    end
  end

  assign samp = s2_q;
`else
  // Sources are already synchronous to clk in this build.
  assign samp = src_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= samp;
  end

  assign rise_o = samp & ~prev_q;

endmodule

// File: rtl/beta_irq_ctrl.sv
// Memory-mapped 8-source interrupt controller for the Beta core. Define BETA_IRQ_SYNC_EN
// to insert 2-flop synchronisers on the request lines.
module beta_irq_ctrl
  import beta_irq_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic             sel,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] svc_clr;
  irq_state_t       state_q;
  logic [4:0]       cause_q;
  logic [4:0]       win;
  logic             irq_q;
  logic             valid;
  logic [3:0]       off;
  logic             wr_hit, rd_hit, cause_rd, ack_wr, take;
  logic [31:0]      active32;
  logic [31:0]      cause_word;
  logic             unused_bits;

  irq_edge_sync #(.W(N_SRC)) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .src_i  (src),
    .rise_o (rise)
  );

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign off         = {addr[3:2], 2'b00};
  assign wr_hit      = we & sel;
  assign rd_hit      = re & sel;
  assign cause_rd    = rd_hit && (off == IRQ_OFF_CAUSE);
  assign ack_wr      = wr_hit && (off == IRQ_OFF_ACK);
  assign unused_bits = ^{addr[1:0], wdata};

  assign active   = pending_q & enable_q;
  assign valid    = |active;
  assign active32 = {{(32 - N_SRC){1'b0}}, active};
  assign win      = irq_prio_enc(active32);
  assign take     = (state_q == ASSERT) && valid && cause_rd;

  // Service clear and W1C apply first; a same-cycle rising edge overrides both.
  always_comb begin
    svc_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      svc_clr[i] = take && (win == 5'(i));
    end
    pending_d = pending_q & ~svc_clr;
    if (wr_hit && (off == IRQ_OFF_PENDING)) pending_d = pending_d & ~wdata[N_SRC-1:0];
    pending_d = pending_d | rise;
    enable_d = enable_q;
    if (wr_hit && (off == IRQ_OFF_ENABLE)) enable_d = wdata[N_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            state_q <= ASSERT;
            irq_q   <= 1'b1;
          end
        end
        ASSERT: begin
          if (!valid) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end else if (cause_rd) begin
            state_q <= SERVICE;
            irq_q   <= 1'b0;
            cause_q <= win;
          end
        end
        SERVICE: begin
          if (ack_wr) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq = irq_q;

  always_comb begin
    cause_word = '0;
    if (state_q == SERVICE) begin
      cause_word[IRQ_VALID_BIT] = 1'b1;
      cause_word[4:0]           = cause_q;
    end else begin
      cause_word[IRQ_VALID_BIT] = valid;
      cause_word[4:0]           = win;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (off)
        IRQ_OFF_PENDING: rdata[N_SRC-1:0] = pending_q;
        IRQ_OFF_ENABLE:  rdata[N_SRC-1:0] = enable_q;
        IRQ_OFF_CAUSE:   rdata = cause_word;
        default:         rdata = '0;
      endcase
    end
  end

endmodule
